// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci front-end units.
// Latency: none (package). Backpressure: none (package).
// Holds the FSM state encoding, datapath widths and the index-to-BCD helper.
package fib_pkg;

    localparam int VAL_W      = 14;
    localparam int FIB_W      = 15;
    localparam int IDX_W      = 5;
    localparam int MAX_IDX    = 21;
    localparam int CONV_ITERS = 14;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        SEARCH = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic       exact;
        logic       err;
        logic [3:0] tens;
        logic [3:0] units;
    } res_t;

    // Index never exceeds MAX_IDX, so tens is at most 2.
    function automatic logic [7:0] idx_to_bcd(input logic [IDX_W-1:0] n);
        logic [3:0]       tens;
        logic [IDX_W-1:0] units;
        if (n >= IDX_W'(20)) begin
            tens  = 4'd2;
            units = n - IDX_W'(20);
        end else if (n >= IDX_W'(10)) begin
            tens  = 4'd1;
            units = n - IDX_W'(10);
        end else begin
            tens  = 4'd0;
            units = n;
        end
        return {tens, 4'(units)};
    endfunction

    function automatic logic bcd_digit_bad(input logic [3:0] d);
        return d > 4'd9;
    endfunction

endpackage

// File: rtl/bcd_to_bin14.sv
// Reverse double-dabble: 4 BCD digits to a 14-bit binary value.
// Latency: 14 cycles from accepted iSTART; oDONE is high in the 14th busy cycle.
// Backpressure: none; iSTART while busy is ignored, oBIN holds until next start.
module bcd_to_bin14
    import fib_pkg::*;
(
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic [15:0]      iBCD,
    output logic             oBUSY,
    output logic             oDONE,
    output logic [VAL_W-1:0] oBIN
);

    localparam int CNT_W = 4;

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [15:0]      r_bcd;
    logic [VAL_W-1:0] r_bin;

    logic [15:0]      w_bcd_sh;
    logic [VAL_W-1:0] w_bin_sh;
    logic [15:0]      w_bcd_adj;
    logic             w_last;

    assign w_last = r_busy && (r_cnt == CNT_W'(CONV_ITERS - 1));

    // Shift the whole {bcd, bin} pair right, then pull each digit back by 3 if it is >= 8.
    always_comb begin
        {w_bcd_sh, w_bin_sh} = {r_bcd, r_bin} >> 1;
        w_bcd_adj = w_bcd_sh;
        for (int d = 0; d < 4; d++) begin
            if (w_bcd_sh[4*d +: 4] >= 4'd8) begin
                w_bcd_adj[4*d +: 4] = w_bcd_sh[4*d +: 4] - 4'd3;
            end
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_bcd  <= '0;
            r_bin  <= '0;
        end else if (!r_busy) begin
            if (iSTART) begin
                r_busy <= 1'b1;
                r_cnt  <= '0;
                r_bcd  <= iBCD;
                r_bin  <= '0;
            end
        end else begin
            r_bcd <= w_bcd_adj;
            r_bin <= w_bin_sh;
            r_cnt <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign oBUSY = r_busy;
    assign oDONE = w_last;
    assign oBIN  = r_bin;

endmodule

// File: rtl/fib_inv_des.sv
// Inverse Fibonacci: smallest n with F(n) >= V for a 4-digit BCD V, n returned as BCD.
// Latency: 16+n cycles (16..37) from accepted start; 1 cycle for a bad digit.
// Backpressure: oREADY high only in IDLE; iSTART elsewhere is ignored.
module fib_inv_des
    import fib_pkg::*;
(
    input  logic       iCLK,
    input  logic       iRESET,
    input  logic       iSTART,
    input  logic [3:0] iBCD3,
    input  logic [3:0] iBCD2,
    input  logic [3:0] iBCD1,
    input  logic [3:0] iBCD0,
    output logic       oREADY,
    output logic       oDONE,
    output logic       oEXACT,
    output logic       oERR,
    output logic [3:0] oBCD1,
    output logic [3:0] oBCD0
);

    state_t           r_state;
    state_t           w_next;

    logic [FIB_W-1:0] r_f0;
    logic [FIB_W-1:0] r_f1;
    logic [IDX_W-1:0] r_n;
    res_t             r_res;

    logic             w_bad_digit;
    logic             w_accept;
    logic             w_conv_start;
    logic             w_conv_busy;
    logic             w_conv_done;
    logic [VAL_W-1:0] w_val;
    logic [FIB_W-1:0] w_val_ext;
    logic             w_hit;

    assign w_bad_digit  = bcd_digit_bad(iBCD3) || bcd_digit_bad(iBCD2) ||
                          bcd_digit_bad(iBCD1) || bcd_digit_bad(iBCD0);
    assign w_accept     = (r_state == IDLE) && iSTART;
    assign w_conv_start = w_accept && !w_bad_digit;

    bcd_to_bin14 u_conv (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iSTART (w_conv_start),
        .iBCD   ({iBCD3, iBCD2, iBCD1, iBCD0}),
        .oBUSY  (w_conv_busy),
        .oDONE  (w_conv_done),
        .oBIN   (w_val)
    );

    assign w_val_ext = {1'b0, w_val};
    assign w_hit     = (r_state == SEARCH) && (r_f0 >= w_val_ext);

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        oREADY = 1'b0;
        oDONE  = 1'b0;
        unique case (r_state)
            IDLE: begin
                oREADY = 1'b1;
                if (iSTART) begin
                    w_next = w_bad_digit ? DONE : CONV;
                end
            end
            CONV: begin
                if (w_conv_done) begin
                    w_next = SEARCH;
                end
            end
            SEARCH: begin
                if (w_hit) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                oDONE  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Walk the sequence one index per cycle; f1 tops out at F(22), inside FIB_W.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_f0 <= '0;
            r_f1 <= '0;
            r_n  <= '0;
        end else if (w_conv_done) begin
            r_f0 <= '0;
            r_f1 <= FIB_W'(1);
            r_n  <= '0;
        end else if ((r_state == SEARCH) && !w_hit && (r_n < IDX_W'(MAX_IDX))) begin
            r_f0 <= r_f1;
            r_f1 <= r_f0 + r_f1;
            r_n  <= r_n + IDX_W'(1);
        end
    end

    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_res <= '0;
        end else if (w_accept && w_bad_digit) begin
            r_res       <= '0;
            r_res.err   <= 1'b1;
        end else if (w_hit) begin
            r_res.exact <= (r_f0 == w_val_ext);
            r_res.err   <= 1'b0;
            {r_res.tens, r_res.units} <= idx_to_bcd(r_n);
        end
    end

    assign oEXACT = r_res.exact;
    assign oERR   = r_res.err;
    assign oBCD1  = r_res.tens;
    assign oBCD0  = r_res.units;

endmodule
